button_debouncer: RTL and testbench

Front-end conditioner for a raw mechanical push-button input. It sits directly upstream of the single-pulse button limiter in the serial/control path. It synchronises the asynchronous pad signal into the `clk` domain, rejects contact bounce with a restartable stability counter, and presents a clean active-high level plus one-cycle press/release strobes.

---
 rtl/button_debouncer.sv | 190 +++++++++++++++++++
 tb/tb_button_debouncer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// button_debouncer: conditions a raw, bouncing push-button pad signal.
//   Synchronises the pad into the clk domain, accepts a level change only
//   after a run of identical samples, and emits a clean level plus
//   one-cycle press/release strobes. All outputs are registered.
//
// Optional feature: define BUTTON_AUTOREPEAT_EN to make press_pulse repeat
//   HOLD_CYCLES after an accepted press and then every REPEAT_CYCLES while
//   the button stays pressed.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   buttonin      in   raw asynchronous pad signal
//   buttonout     out  debounced level, 1 = pressed
//   press_pulse   out  one-cycle strobe per accepted press (and auto-repeat)
//   release_pulse out  one-cycle strobe per accepted release
module button_debouncer #(
  parameter int unsigned STABLE_CYCLES = 500000,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned HOLD_CYCLES   = 25000000,
  parameter int unsigned REPEAT_CYCLES = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic buttonin,
  output logic buttonout,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  // Parameter legality checks at elaboration
  if (STABLE_CYCLES < 2 || STABLE_CYCLES > (1 << 24)) begin : g_bad_stable
    $error("button_debouncer: STABLE_CYCLES out of range 2..2^24");
  end
  if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("button_debouncer: HOLD_CYCLES and REPEAT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    S_RELEASED  = 2'd0,
    S_ARMING    = 2'd1,
    S_PRESSED   = 2'd2,
    S_DISARMING = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync1_q, sync2_q;
  logic          buttonout_q, buttonout_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          rpt_fire_c;
  logic          s_c;

  // Two-flop synchroniser; stored in pressed-sense so reset value 0 = released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= buttonin ^ ACTIVE_LOW;
      sync2_q <= sync1_q;
    end
  end

  assign s_c = sync2_q;

  // State register, stability counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RELEASED;
      cnt_q       <= '0;
      buttonout_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buttonout_q <= buttonout_d;
      press_q     <= press_d;
      release_q   <= release_d;
    end
  end

  // Next-state logic; any reversal during a window restarts it from scratch
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_RELEASED: begin
        if (s_c) begin
          state_d = S_ARMING;
          cnt_d   = '0;
        end
      end
      S_ARMING: begin
        if (!s_c) begin
          state_d = S_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PRESSED: begin
        if (!s_c) begin
          state_d = S_DISARMING;
          cnt_d   = '0;
        end
      end
      S_DISARMING: begin
        if (s_c) begin
          state_d = S_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the transition being taken this cycle
  always_comb begin
    buttonout_d = 1'b0;
    press_d     = 1'b0;
    release_d   = 1'b0;
    buttonout_d = (state_d == S_PRESSED) || (state_d == S_DISARMING);
    press_d     = ((state_q == S_ARMING) && (state_d == S_PRESSED)) || rpt_fire_c;
    release_d   = (state_q == S_DISARMING) && (state_d == S_RELEASED);
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned RW      = ($clog2(RPT_MAX) < 1) ? 1 : $clog2(RPT_MAX);
  localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rpt_q, rpt_d;
  logic          rpt_phase_q, rpt_phase_d;

  // Repeat timer: runs in PRESSED, holds in DISARMING, idle-clear otherwise.
  // The phase bit switches the terminal count from hold delay to repeat period.
  always_comb begin
    rpt_d       = rpt_q;
    rpt_phase_d = rpt_phase_q;
    rpt_fire_c  = 1'b0;
    if (state_q == S_PRESSED) begin
      if (rpt_q == (rpt_phase_q ? REP_LAST : HOLD_LAST)) begin
        rpt_fire_c  = 1'b1;
        rpt_d       = '0;
        rpt_phase_d = 1'b1;
      end else begin
        rpt_d = rpt_q + RW'(1);
      end
    end else if (state_q != S_DISARMING) begin
      rpt_d       = '0;
      rpt_phase_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_q       <= '0;
      rpt_phase_q <= 1'b0;
    end else begin
      rpt_q       <= rpt_d;
      rpt_phase_q <= rpt_phase_d;
    end
  end
`else
  assign rpt_fire_c = 1'b0;
`endif

  assign buttonout     = buttonout_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer with STABLE_CYCLES=8,
// ACTIVE_LOW=1, HOLD_CYCLES=20, REPEAT_CYCLES=5.
module tb_button_debouncer;

  localparam int STABLE = 8;
  localparam int HOLD   = 20;
  localparam int REPEAT = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic buttonin = 1'b1;
  logic buttonout, press_pulse, release_pulse;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_press = 0;
  int n_rel = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_debouncer #(
    .STABLE_CYCLES(STABLE),
    .ACTIVE_LOW   (1'b1),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REPEAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .buttonin     (buttonin),
    .buttonout    (buttonout),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  // Reference model: the pad value seen two edges ago is the sample; a level
  // change is accepted on the (STABLE+1)-th consecutive differing sample.
  bit m_p1 = 1'b0, m_p2 = 1'b0, m_s = 1'b0;
  bit m_lvl = 1'b0, m_press = 1'b0, m_rel = 1'b0;
  int m_run = 0;
`ifdef BUTTON_AUTOREPEAT_EN
  int m_age = 0;
`endif

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_p1 = 1'b0; m_p2 = 1'b0; m_lvl = 1'b0; m_run = 0;
        m_press = 1'b0; m_rel = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
        m_age = 0;
`endif
      end else begin
        m_s  = m_p2;
        m_p2 = m_p1;
        m_p1 = ~buttonin;
        m_press = 1'b0;
        m_rel   = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
        // age advances only while settled pressed (no pending release)
        if (m_lvl && m_run == 0) begin
          m_age++;
          if (m_age == HOLD || (m_age > HOLD && (m_age - HOLD) % REPEAT == 0))
            m_press = 1'b1;
        end
`endif
        if (m_s != m_lvl) begin
          m_run++;
          if (m_run == STABLE + 1) begin
            m_lvl = m_s;
            m_run = 0;
            if (m_s) m_press = 1'b1;
            else     m_rel   = 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
            m_age = 0;
`endif
          end
        end else begin
          m_run = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("model_buttonout", 32'(buttonout), 32'(m_lvl));
      chk("model_press", 32'(press_pulse), 32'(m_press));
      chk("model_release", 32'(release_pulse), 32'(m_rel));
      if (press_pulse === 1'b1) n_press++;
      if (release_pulse === 1'b1) n_rel++;
    end
  end

  // Advance to just after the n-th following falling edge
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_press(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (press_pulse === 1'b1) begin
        at = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL wait_press: no press_pulse within %0d cycles (cycle %0d)", budget, cyc);
  endtask

  task automatic wait_rel(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (release_pulse === 1'b1) begin
        at = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL wait_rel: no release_pulse within %0d cycles (cycle %0d)", budget, cyc);
  endtask

  int k, at, base_p, base_r, first, acc;

  initial begin
    // Reset held with a toggling pad
    rst_n = 1'b0;
    buttonin = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      buttonin = ~buttonin;
    end
    chk("reset_outputs", 32'({buttonout, press_pulse, release_pulse}), 32'd0);
    buttonin = 1'b1;
    tick(1);
    rst_n = 1'b1;
    base_p = n_press;
    base_r = n_rel;
    tick(50);
    chk("post_reset_level", 32'(buttonout), 32'd0);
    chk("post_reset_strobes", 32'((n_press - base_p) + (n_rel - base_r)), 32'd0);

    // Clean press
    buttonin = 1'b0;
    k = cyc + 1;
    wait_press(20, at);
    chk("press_latency", 32'(at - k), 32'd10);
    chk("press_level", 32'(buttonout), 32'd1);
    tick(1);
    chk("press_single_cycle", 32'(press_pulse), 32'd0);

    // Clean release
    tick(3);
    buttonin = 1'b1;
    k = cyc + 1;
    wait_rel(20, at);
    chk("release_latency", 32'(at - k), 32'd10);
    chk("release_level", 32'(buttonout), 32'd0);

    // Bounce: 13 toggles every 3 cycles ending pressed
    tick(5);
    base_p = n_press;
    for (int i = 0; i < 13; i++) begin
      buttonin = ~buttonin;
      k = cyc + 1;
      tick(3);
    end
    chk("bounce_no_strobe", 32'(n_press - base_p), 32'd0);
    wait_press(20, at);
    chk("bounce_latency", 32'(at - k), 32'd10);
    chk("bounce_one_press", 32'(n_press - base_p), 32'd1);

    // Release with a one-cycle glitch back to pressed
    tick(2);
    base_r = n_rel;
    buttonin = 1'b1;
    tick(5);
    chk("glitch_hold_a", 32'(buttonout), 32'd1);
    buttonin = 1'b0;
    tick(1);
    buttonin = 1'b1;
    k = cyc + 1;
    chk("glitch_hold_b", 32'(buttonout), 32'd1);
    wait_rel(20, at);
    chk("glitch_release_latency", 32'(at - k), 32'd10);
    chk("glitch_one_release", 32'(n_rel - base_r), 32'd1);

    // Async reset with the ARMING counter at 5
    tick(3);
    buttonin = 1'b0;
    k = cyc + 1;
    tick(8);
    rst_n = 1'b0;
    #1;
    chk("arming_reset_level", 32'(buttonout), 32'd0);
    tick(2);
    rst_n = 1'b1;
    k = cyc + 1;
    wait_press(20, at);
    chk("rearm_latency", 32'(at - k), 32'd10);

    // Async reset mid-PRESSED clears outputs immediately
    tick(3);
    chk("pressed_before_reset", 32'(buttonout), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_clear_level", 32'(buttonout), 32'd0);
    tick(1);
    rst_n = 1'b1;
    k = cyc + 1;
    wait_press(20, at);
    chk("reaccept_latency", 32'(at - k), 32'd10);
    acc = at;

    // Long hold past accept
    base_p = n_press - 1;
    first = -1;
    for (int i = 0; i < 59; i++) begin
      tick(1);
      if (press_pulse === 1'b1 && first < 0) first = cyc - acc;
    end
`ifdef BUTTON_AUTOREPEAT_EN
    chk("repeat_first_offset", 32'(first), 32'd20);
    chk("repeat_count", 32'(n_press - base_p), 32'd9);
`else
    chk("no_repeat", 32'(first), 32'hFFFF_FFFF);
    chk("single_press", 32'(n_press - base_p), 32'd1);
`endif

    // Final release
    buttonin = 1'b1;
    k = cyc + 1;
    wait_rel(20, at);
    chk("final_release_latency", 32'(at - k), 32'd10);
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
